// File: rtl/apb_master.sv
// Single-outstanding APB requester: valid/ready command in, APB SETUP/ACCESS out, valid/ready response back.
// Optional ACCESS-phase wait-state timeout is enabled by defining APB_TIMEOUT_EN.
module apb_master #(
  parameter int ADDRW   = 32,
  parameter int DATAW   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [ADDRW-1:0] cmd_addr,
  input  logic [DATAW-1:0] cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DATAW-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic [ADDRW-1:0] paddr,
  output logic             pwrite,
  output logic             psel,
  output logic             penable,
  output logic [DATAW-1:0] pwdata,
  input  logic [DATAW-1:0] prdata,
  input  logic             pready,
  input  logic             pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t           state, state_n;
  logic             cmd_ready_n, rsp_valid_n, rsp_err_n, pwrite_n, psel_n, penable_n;
  logic [DATAW-1:0] rsp_rdata_n, pwdata_n;
  logic [ADDRW-1:0] paddr_n;

`ifdef APB_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);
  logic [CW-1:0] wait_cnt, wait_cnt_n;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwdata    <= '0;
`ifdef APB_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      state     <= state_n;
      cmd_ready <= cmd_ready_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
      rsp_err   <= rsp_err_n;
      paddr     <= paddr_n;
      pwrite    <= pwrite_n;
      psel      <= psel_n;
      penable   <= penable_n;
      pwdata    <= pwdata_n;
`ifdef APB_TIMEOUT_EN
      wait_cnt  <= wait_cnt_n;
`endif
    end
  end

  // Every output is a register; this block computes the value each one takes at the next edge.
  always_comb begin
    state_n     = state;
    rsp_valid_n = rsp_valid;
    rsp_rdata_n = rsp_rdata;
    rsp_err_n   = rsp_err;
    paddr_n     = paddr;
    pwrite_n    = pwrite;
    psel_n      = psel;
    penable_n   = penable;
    pwdata_n    = pwdata;
`ifdef APB_TIMEOUT_EN
    wait_cnt_n  = wait_cnt;
`endif
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_addr[1:0] == 2'b00) begin
            paddr_n  = cmd_addr;
            pwrite_n = cmd_write;
            pwdata_n = cmd_write ? cmd_wdata : '0;
            psel_n   = 1'b1;
            state_n  = SETUP;
          end else begin
            rsp_valid_n = 1'b1;
            rsp_err_n   = 1'b1;
            rsp_rdata_n = '0;
            state_n     = RESP;
          end
        end
      end
      SETUP: begin
        penable_n = 1'b1;
        state_n   = ACCESS;
`ifdef APB_TIMEOUT_EN
        wait_cnt_n = '0;
`endif
      end
      ACCESS: begin
        // A ready slave always wins over the timeout on the same cycle.
        if (pready) begin
          rsp_rdata_n = pwrite ? '0 : prdata;
          rsp_err_n   = pslverr;
          rsp_valid_n = 1'b1;
          psel_n      = 1'b0;
          penable_n   = 1'b0;
          state_n     = RESP;
        end
`ifdef APB_TIMEOUT_EN
        else if (wait_cnt == LIMIT) begin
          rsp_rdata_n = '0;
          rsp_err_n   = 1'b1;
          rsp_valid_n = 1'b1;
          psel_n      = 1'b0;
          penable_n   = 1'b0;
          state_n     = RESP;
        end else begin
          wait_cnt_n = wait_cnt + 1'b1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    cmd_ready_n = (state_n == IDLE);
  end

endmodule

// File: tb/tb_apb_master.sv
// Randomized self-checking bench for apb_master: acts as requester, APB slave and response consumer,
// and predicts every output cycle from the transfer rules (timing counts, data selection, timeout limit).
module tb_apb_master;
  localparam int ADDRW   = 32;
  localparam int DATAW   = 32;
  localparam int TIMEOUT = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready, cmd_write;
  logic [ADDRW-1:0] cmd_addr;
  logic [DATAW-1:0] cmd_wdata;
  logic             rsp_valid, rsp_ready, rsp_err;
  logic [DATAW-1:0] rsp_rdata;
  logic [ADDRW-1:0] paddr;
  logic             pwrite, psel, penable;
  logic [DATAW-1:0] pwdata, prdata;
  logic             pready, pslverr;

  int checks   = 0;
  int failures = 0;

  apb_master #(.ADDRW(ADDRW), .DATAW(DATAW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic waitIdle;
    int guard = 0;
    while (!cmd_ready && guard < 20) begin
      tick;
      guard++;
    end
    checkOutput("cmd_ready_idle", cmd_ready, 1);
  endtask

  // One complete command: drive it, play the slave with the given wait states, then consume the response.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input int waits, input logic err,
                               input int rsp_delay, input logic hold_valid);
    logic        misaligned;
    logic        abort;
    int          n_wait;
    logic [31:0] exp_rdata, exp_wdata;
    logic        exp_err;
    logic [31:0] junk;
    misaligned = (addr[1:0] != 2'b00);
    exp_wdata  = wr ? wdata : 32'h0;
    abort      = 1'b0;
    n_wait     = waits;
    waitIdle;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    tick;
    junk      = $urandom;
    cmd_valid = hold_valid;
    cmd_write = junk[0];
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    checkOutput("cmd_ready_busy", cmd_ready, 0);
    if (misaligned) begin
      exp_err   = 1'b1;
      exp_rdata = 32'h0;
      checkOutput("misalign_psel", psel, 0);
    end else begin
      checkOutput("setup_psel", psel, 1);
      checkOutput("setup_penable", penable, 0);
      checkOutput("setup_paddr", paddr, addr);
      checkOutput("setup_pwrite", pwrite, wr);
      checkOutput("setup_pwdata", pwdata, exp_wdata);
      checkOutput("setup_rsp_valid", rsp_valid, 0);
      tick;
`ifdef APB_TIMEOUT_EN
      if (waits >= TIMEOUT) begin
        abort  = 1'b1;
        n_wait = TIMEOUT;
      end
`endif
      for (int i = 0; i <= n_wait; i++) begin
        if (i == n_wait && abort) break;
        checkOutput("access_psel", psel, 1);
        checkOutput("access_penable", penable, 1);
        checkOutput("access_paddr", paddr, addr);
        checkOutput("access_pwdata", pwdata, exp_wdata);
        checkOutput("access_rsp_valid", rsp_valid, 0);
        checkOutput("access_cmd_ready", cmd_ready, 0);
        if (i < n_wait) begin
          junk    = $urandom;
          pready  = 1'b0;
          pslverr = junk[0];
          prdata  = $urandom;
        end else begin
          pready  = 1'b1;
          pslverr = err;
          prdata  = rdata;
        end
        tick;
      end
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = $urandom;
      exp_err   = abort ? 1'b1 : err;
      exp_rdata = (abort || wr) ? 32'h0 : rdata;
    end
    checkOutput("rsp_valid", rsp_valid, 1);
    checkOutput("rsp_err", rsp_err, exp_err);
    checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
    checkOutput("resp_psel", psel, 0);
    checkOutput("resp_penable", penable, 0);
    for (int d = 0; d < rsp_delay; d++) begin
      rsp_ready = 1'b0;
      tick;
      checkOutput("hold_rsp_valid", rsp_valid, 1);
      checkOutput("hold_rsp_err", rsp_err, exp_err);
      checkOutput("hold_rsp_rdata", rsp_rdata, exp_rdata);
      checkOutput("hold_cmd_ready", cmd_ready, 0);
      checkOutput("hold_psel", psel, 0);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    checkOutput("done_rsp_valid", rsp_valid, 0);
    checkOutput("done_cmd_ready", cmd_ready, 1);
    checkOutput("done_psel", psel, 0);
  endtask

  task automatic resetMidTransfer;
    waitIdle;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_0020;
    cmd_wdata = 32'h0;
    pready    = 1'b0;
    tick;
    cmd_valid = 1'b0;
    tick;
    checkOutput("pre_reset_penable", penable, 1);
    rst = 1'b1;
    tick;
    checkOutput("reset_psel", psel, 0);
    checkOutput("reset_penable", penable, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    pready = 1'b1;
    tick;
    pready = 1'b0;
    checkOutput("post_reset_cmd_ready", cmd_ready, 1);
    checkOutput("post_reset_rsp_valid", rsp_valid, 0);
    checkOutput("post_reset_psel", psel, 0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a, r;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    tick;
    tick;
    checkOutput("rst_cmd_ready", cmd_ready, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 0);
    checkOutput("rst_rsp_err", rsp_err, 0);
    checkOutput("rst_paddr", paddr, 0);
    checkOutput("rst_pwrite", pwrite, 0);
    checkOutput("rst_psel", psel, 0);
    checkOutput("rst_penable", penable, 0);
    checkOutput("rst_pwdata", pwdata, 0);
    rst = 1'b0;
    tick;

    applyStimulus(1'b1, 32'h0000_000C, 32'h1234_0042, 32'hDEAD_BEEF, 0, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 32'h0000_0014, 32'h5555_5555, 32'h80DC_0324, 0, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 32'h0000_0008, 32'h0, 32'hCAFE_F00D, 3, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 32'h0000_0006, 32'h0, 32'h1111_2222, 0, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 32'h0000_0010, 32'h0, 32'hA5A5_0F0F, 1, 1'b1, 0, 1'b0);
    applyStimulus(1'b1, 32'h0000_0030, 32'h0BAD_CAFE, 32'h0, 0, 1'b1, 5, 1'b1);
    applyStimulus(1'b1, 32'h0000_0040, 32'h7777_0001, 32'h0, TIMEOUT - 1, 1'b0, 1, 1'b0);
    applyStimulus(1'b0, 32'h0000_0044, 32'h0, 32'h3C3C_3C3C, TIMEOUT + 2, 1'b0, 0, 1'b1);
    resetMidTransfer();

    for (int n = 0; n < 150; n++) begin
      a = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      r = $urandom;
      applyStimulus(1'($urandom_range(0, 1)), a, $urandom, r, $urandom_range(0, 6),
                    ($urandom_range(0, 3) == 0), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
